control_unit_mc: RTL and testbench
==================================

Name: control_unit_mc

Overview:
- Parametrised successor to the fixed-latency multicycle control FSM.
- Sequences fetch/decode/execute/memory/writeback with ready/valid handshakes to instruction and data memory, so memory latency is variable rather than assumed single-cycle.
- Adds a memory-timeout fault, a proper halt/resume state, per-opcode register-write gating and a retired-instruction counter.
- Drives the same datapath controls: PC load, register write, memory enables, immediate select, data select, branch type.

Parameters:
OP_W, 4, opcode width; the opcode map occupies the low 4 bits, and any nonzero upper bit makes the opcode illegal
TIMEOUT, 15, max cycles spent in MEM waiting for dmem_ready before faulting (range 1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op_code  in  OP_W  instruction opcode, sampled in DECODE
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
cont  in  1  resume from HALTED
ifetch  out  1  instruction fetch request
IRload  out  1  load instruction register
loadPC  out  1  advance/load PC
writeReg  out  1  register file write enable
MemEn  out  1  data memory enable
MemWen  out  1  data memory write
IMMsel  out  1  1 = immediate operand
DataSel  out  2  00 ALU/MOVE, 01 memory, 10 CMOV
BRANCH  out  3  000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ
halted  out  1  core stopped
mem_fault  out  1  sticky data-memory timeout
illegal_op  out  1  one-cycle pulse on illegal opcode
retired  out  CNT_W  instructions retired
state  out  3  current state, for debug

Behaviour:
- Opcode map: 0 ALU, 1 ALU_IMM, 2 LOAD, 3 STORE, 4 BR, 5 BMI, 6 BPL, 7 BZ, 8 MOVE, 9 CMOV, E NOP, F HALT.
- Codes A-D and nonzero upper bits are illegal: pulse illegal_op in DECODE, then execute as NOP.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALTED=5. Codes 6 and 7 are unreachable and recover to FETCH on the next edge.
- Reset, sampled on clk edge:
  - state=FETCH, op_q=NOP, timeout counter=0, mem_fault=0, retired=0.
  - All outputs are 0 while reset is high; ifetch is gated by ~reset.
- FETCH:
  - ifetch=1.
  - When imem_ready=1: IRload=1 in the same cycle, next state DECODE. Otherwise remain in FETCH indefinitely (no timeout).
- DECODE: op_q <= op_code; next state EXECUTE.
- Datapath control timing:
  - IMMsel, DataSel and BRANCH decode from op_q and are valid in EXECUTE, MEM and WB.
  - They are 0 in FETCH, DECODE and HALTED.
- Datapath control values:
  - IMMsel=1 for ALU_IMM, LOAD, STORE and branches.
  - DataSel=01 for LOAD, 10 for CMOV, otherwise 00.
- EXECUTE next state: LOAD/STORE go to MEM; HALT goes to HALTED; all others go to WB.
- MEM:
  - MemEn=1; MemWen=1 only for STORE.
  - On dmem_ready=1, next state is WB and the counter clears.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 without ready, set mem_fault=1, clear the counter, and go to HALTED.
  - dmem_ready on the final counted cycle wins over the timeout.
- WB:
  - loadPC=1 for exactly one cycle.
  - writeReg=1 only for ALU, ALU_IMM, LOAD, MOVE, CMOV. It stays 0 for STORE, branches, NOP, HALT and illegal opcodes.
  - retired increments and wraps modulo 2^CNT_W.
  - Next state FETCH.
- HALTED:
  - halted=1.
  - If cont=1 and mem_fault=0: next state WB, so the PC advances past the HALT and retired counts it.
  - cont is ignored while mem_fault=1; only reset clears mem_fault.
- Latency with memories ready at first request: 4 cycles for non-memory ops, 5 for LOAD/STORE.
- imem_ready and dmem_ready are ignored outside FETCH and MEM respectively.
- Reset mid-access (any state) aborts the access; MemEn/ifetch drop in the reset cycle.

Test Plan:
- Reset, then opcode 0 with imem_ready=1 held → state sequence 0,1,2,4,0; writeReg=1 and loadPC=1 only in cycle 4; retired=1.
- LOAD with dmem_ready low for 3 MEM cycles then high → MemEn=1 for 4 cycles, MemWen=0, DataSel=01 in MEM/WB, writeReg=1 in WB; total 8 cycles.
- STORE then BZ (op 7) → STORE: MemWen=1, writeReg=0. BZ: BRANCH=100, IMMsel=1, writeReg=0, loadPC=1.
- HALT with cont=0 for 10 cycles, then cont=1 → halted=1 throughout; after cont=1, one WB cycle with loadPC=1, writeReg=0, then FETCH; retired +1.
- LOAD with dmem_ready never asserted, TIMEOUT=15 → after 15 MEM cycles mem_fault=1 and HALTED; cont=1 has no effect; reset clears all.
- op_code=4'hB → illegal_op pulses in DECODE; behaves as NOP (loadPC=1, writeReg=0). Also reset asserted in MEM → FETCH next edge, MemEn=0 during the reset cycle.

Source files
------------

// File: rtl/control_unit_mc.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback sequencing with
// ready-based memory handshakes, memory timeout fault, halt/resume and retire counter.
module control_unit_mc #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op_code,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             cont,
    output logic             ifetch,
    output logic             IRload,
    output logic             loadPC,
    output logic             writeReg,
    output logic             MemEn,
    output logic             MemWen,
    output logic             IMMsel,
    output logic [1:0]       DataSel,
    output logic [2:0]       BRANCH,
    output logic             halted,
    output logic             mem_fault,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALTED  = 3'd5
    } state_t;

    localparam logic [3:0] OP_ALU     = 4'h0;
    localparam logic [3:0] OP_ALU_IMM = 4'h1;
    localparam logic [3:0] OP_LOAD    = 4'h2;
    localparam logic [3:0] OP_STORE   = 4'h3;
    localparam logic [3:0] OP_BR      = 4'h4;
    localparam logic [3:0] OP_BMI     = 4'h5;
    localparam logic [3:0] OP_BPL     = 4'h6;
    localparam logic [3:0] OP_BZ      = 4'h7;
    localparam logic [3:0] OP_MOVE    = 4'h8;
    localparam logic [3:0] OP_CMOV    = 4'h9;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [3:0]         op_q;
    logic [7:0]         to_cnt_q, to_cnt_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   retired_q;

    logic               upper_nz;
    logic               op_illegal;
    logic [3:0]         op_dec;

    logic               ifetch_c, irload_c, loadpc_c, wreg_c;
    logic               memen_c, memwen_c, illegal_c, halted_c;
    logic               imm_c;
    logic [1:0]         dsel_c;
    logic [2:0]         br_c;

    generate
        if (OP_W > 4) begin : g_upper
            assign upper_nz = |op_code[OP_W-1:4];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    // Illegal opcodes are latched as NOP so the rest of the pipeline never sees them.
    assign op_illegal = upper_nz || (op_code[3:0] inside {[4'hA:4'hD]});
    assign op_dec     = op_illegal ? OP_NOP : op_code[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_NOP;
            to_cnt_q  <= 8'd0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_d;
            if (state_q == S_DECODE) begin
                op_q <= op_dec;
            end
            if (state_q == S_WB) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Handshakes: the FSM holds its request (ifetch in FETCH, MemEn in MEM) every
    // cycle until the matching ready is seen high on a rising edge; a ready
    // outside its own state carries no meaning and is ignored.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        fault_d   = fault_q;
        ifetch_c  = 1'b0;
        irload_c  = 1'b0;
        loadpc_c  = 1'b0;
        wreg_c    = 1'b0;
        memen_c   = 1'b0;
        memwen_c  = 1'b0;
        illegal_c = 1'b0;
        halted_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ifetch_c = 1'b1;
                if (imem_ready) begin
                    irload_c = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal_c = op_illegal;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op_q == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                memen_c  = 1'b1;
                memwen_c = (op_q == OP_STORE);
                // A ready on the last counted cycle still completes the access.
                if (dmem_ready) begin
                    to_cnt_d = 8'd0;
                    state_d  = S_WB;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = 8'd0;
                    fault_d  = 1'b1;
                    state_d  = S_HALTED;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                loadpc_c = 1'b1;
                wreg_c   = op_q inside {OP_ALU, OP_ALU_IMM, OP_LOAD, OP_MOVE, OP_CMOV};
                state_d  = S_FETCH;
            end
            S_HALTED: begin
                halted_c = 1'b1;
                if (cont && !fault_q) begin
                    state_d = S_WB;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        imm_c  = 1'b0;
        dsel_c = 2'b00;
        br_c   = 3'b000;
        if (state_q inside {S_EXECUTE, S_MEM, S_WB}) begin
            imm_c = op_q inside {OP_ALU_IMM, OP_LOAD, OP_STORE, OP_BR, OP_BMI, OP_BPL, OP_BZ};
            if (op_q == OP_LOAD) begin
                dsel_c = 2'b01;
            end else if (op_q == OP_CMOV) begin
                dsel_c = 2'b10;
            end
            case (op_q)
                OP_BR:   br_c = 3'b001;
                OP_BMI:  br_c = 3'b010;
                OP_BPL:  br_c = 3'b011;
                OP_BZ:   br_c = 3'b100;
                default: br_c = 3'b000;
            endcase
        end
    end

    // Every output is forced low while reset is held, including the registered ones.
    assign ifetch     = ifetch_c  & ~reset;
    assign IRload     = irload_c  & ~reset;
    assign loadPC     = loadpc_c  & ~reset;
    assign writeReg   = wreg_c    & ~reset;
    assign MemEn      = memen_c   & ~reset;
    assign MemWen     = memwen_c  & ~reset;
    assign IMMsel     = imm_c     & ~reset;
    assign DataSel    = reset ? 2'b00 : dsel_c;
    assign BRANCH     = reset ? 3'b000 : br_c;
    assign halted     = halted_c  & ~reset;
    assign mem_fault  = fault_q   & ~reset;
    assign illegal_op = illegal_c & ~reset;
    assign retired    = reset ? '0 : retired_q;
    assign state      = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: an instruction-level model expands each instruction
// into its expected cycle trace, which is then replayed against the DUT.
module tb_control_unit_mc;

    localparam int OP_W    = 5;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int OW      = 18 + CNT_W;
    localparam int IW      = 4 + OP_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [OP_W-1:0]  op_code;
    logic             imem_ready, dmem_ready, cont;
    logic             ifetch, IRload, loadPC, writeReg, MemEn, MemWen, IMMsel;
    logic [1:0]       DataSel;
    logic [2:0]       BRANCH;
    logic             halted, mem_fault, illegal_op;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    control_unit_mc #(.OP_W(OP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op_code(op_code),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .cont(cont),
        .ifetch(ifetch), .IRload(IRload), .loadPC(loadPC), .writeReg(writeReg),
        .MemEn(MemEn), .MemWen(MemWen), .IMMsel(IMMsel), .DataSel(DataSel),
        .BRANCH(BRANCH), .halted(halted), .mem_fault(mem_fault),
        .illegal_op(illegal_op), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] in_q[$];
    logic [OW-1:0] exp_q[$];
    string         tag_q[$];
    int            total = 0;
    int            bad   = 0;

    logic [CNT_W-1:0] m_retired;
    logic             m_fault;

    logic             d_rst, d_imr, d_dmr, d_cont;
    logic [OP_W-1:0]  d_op;
    logic [2:0]       x_st, x_br;
    logic             x_ifetch, x_irload, x_loadpc, x_wreg, x_memen, x_memwen, x_imm;
    logic [1:0]       x_dsel;
    logic             x_halted, x_fault, x_illegal;
    logic [CNT_W-1:0] x_retired;

    task automatic base(input logic [2:0] st);
        d_rst  = 1'b0;
        d_imr  = 1'($urandom_range(0, 1));
        d_dmr  = 1'($urandom_range(0, 1));
        d_cont = 1'($urandom_range(0, 1));
        d_op   = OP_W'($urandom);
        x_st = st; x_ifetch = 0; x_irload = 0; x_loadpc = 0; x_wreg = 0;
        x_memen = 0; x_memwen = 0; x_imm = 0; x_dsel = 2'b00; x_br = 3'b000;
        x_halted = 0; x_illegal = 0; x_fault = m_fault; x_retired = m_retired;
    endtask

    task automatic ctrl(input logic [3:0] eff);
        x_imm  = (eff >= 4'd1 && eff <= 4'd7);
        x_dsel = (eff == 4'd2) ? 2'b01 : (eff == 4'd9) ? 2'b10 : 2'b00;
        x_br   = (eff >= 4'd4 && eff <= 4'd7) ? 3'(eff - 4'd3) : 3'b000;
    endtask

    task automatic push(input string tag);
        in_q.push_back({d_rst, d_imr, d_dmr, d_cont, d_op});
        exp_q.push_back({x_st, x_ifetch, x_irload, x_loadpc, x_wreg, x_memen, x_memwen,
                         x_imm, x_dsel, x_br, x_halted, x_fault, x_illegal, x_retired});
        tag_q.push_back(tag);
    endtask

    task automatic reset_step();
        base(3'd0);
        d_rst = 1'b1;
        x_fault = 1'b0;
        x_retired = '0;
        push("reset");
        m_retired = '0;
        m_fault = 1'b0;
    endtask

    task automatic play();
        logic [IW-1:0] iv;
        logic [OW-1:0] obs, exp;
        string tag;
        while (in_q.size() > 0) begin
            @(posedge clk);
            #1;
            iv = in_q.pop_front();
            {reset, imem_ready, dmem_ready, cont, op_code} = iv;
            @(negedge clk);
            obs = {state, ifetch, IRload, loadPC, writeReg, MemEn, MemWen, IMMsel,
                   DataSel, BRANCH, halted, mem_fault, illegal_op, retired};
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // iw: fetch wait cycles, dw: data wait cycles (>= TIMEOUT never answers),
    // hw: halted cycles before cont, abort_at: reset after this many MEM cycles (0 = none).
    task automatic gen_instr(input logic [OP_W-1:0] op, input int iw, input int dw,
                             input int hw, input int abort_at);
        logic       legal;
        logic [3:0] eff;
        int         nrdy;
        legal = (op < 16) && !(op >= 5'hA && op <= 5'hD);
        eff   = legal ? op[3:0] : 4'hE;
        for (int i = 0; i < iw; i++) begin
            base(3'd0); d_imr = 1'b0; x_ifetch = 1'b1; push("fetch_wait");
        end
        base(3'd0); d_imr = 1'b1; x_ifetch = 1'b1; x_irload = 1'b1; push("fetch");
        base(3'd1); d_op = op; x_illegal = !legal; push("decode");
        base(3'd2); ctrl(eff); push("execute");
        if (eff == 4'd2 || eff == 4'd3) begin
            nrdy = (dw >= TIMEOUT) ? TIMEOUT : dw;
            for (int i = 0; i < nrdy; i++) begin
                if (abort_at > 0 && i == abort_at) begin
                    reset_step();
                    play();
                    return;
                end
                base(3'd3); ctrl(eff); d_dmr = 1'b0; x_memen = 1'b1;
                x_memwen = (eff == 4'd3); push("mem_wait");
            end
            if (dw >= TIMEOUT) begin
                m_fault = 1'b1;
                for (int i = 0; i < hw + 2; i++) begin
                    base(3'd5); x_halted = 1'b1; d_cont = (i % 2 == 0); push("fault_halt");
                end
                reset_step();
                play();
                return;
            end
            base(3'd3); ctrl(eff); d_dmr = 1'b1; x_memen = 1'b1;
            x_memwen = (eff == 4'd3); push("mem_ready");
        end else if (eff == 4'hF) begin
            for (int i = 0; i < hw; i++) begin
                base(3'd5); x_halted = 1'b1; d_cont = 1'b0; push("halt_wait");
            end
            base(3'd5); x_halted = 1'b1; d_cont = 1'b1; push("resume");
        end
        base(3'd4); ctrl(eff); x_loadpc = 1'b1;
        x_wreg = eff inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
        push("wb");
        m_retired = m_retired + 1'b1;
        play();
    endtask

    initial begin
        int r, dw, ab;
        logic [OP_W-1:0] op;
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; cont = 1'b0; op_code = '0;
        m_retired = '0; m_fault = 1'b0;

        reset_step(); reset_step(); play();

        gen_instr(5'h0, 0, 0, 0, 0);
        gen_instr(5'h2, 0, 3, 0, 0);
        gen_instr(5'h3, 2, 0, 0, 0);
        gen_instr(5'h7, 0, 0, 0, 0);
        gen_instr(5'hF, 0, 0, 10, 0);
        gen_instr(5'hB, 1, 0, 0, 0);
        gen_instr(5'h13, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) gen_instr(OP_W'(k), 0, 1, 1, 0);
        gen_instr(5'h2, 0, TIMEOUT - 1, 0, 0);
        gen_instr(5'h3, 0, 10, 0, 0);
        gen_instr(5'h2, 0, TIMEOUT - 1, 0, 0);
        gen_instr(5'h2, 0, 6, 0, 3);
        gen_instr(5'h3, 0, TIMEOUT - 1, 0, 0);
        gen_instr(5'h2, 0, TIMEOUT + 5, 4, 0);
        gen_instr(5'h8, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) op = OP_W'($urandom_range(0, 31));
            else op = OP_W'($urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            dw = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            ab = ($urandom_range(0, 15) == 0 && dw >= 2 && dw < TIMEOUT) ? 1 : 0;
            gen_instr(op, $urandom_range(0, 3), dw, $urandom_range(0, 3), ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
